// File: rtl/spi_target_apb.sv
// spi_target_apb
// APB-attached SPI target. SCLK, CS_N and MOSI are oversampled in the clk domain,
// so the whole block runs on one clock. Software loads one TX holding register and
// collects completed words from one RX register. irq flags received words and errors.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   PSEL..PWDATA    APB target inputs (byte addresses 0x0 CTRL, 0x4 STATUS,
//                   0x8 TXDATA, 0xC RXDATA)
//   PRDATA, PREADY  APB read data (0 outside read access phase), zero wait states
//   sclk, cs_n, mosi  SPI pins from the master
//   miso, miso_oe   serial data out (MSB first) and pad enable while selected
//   irq             level interrupt
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not selected, waiting for cs_n falling with en=1
// SHIFT | exchanging bits on sclk edges
// DONE  | one cycle: hand the word to RXDATA, start the next word if cs_n low
module spi_target_apb #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              irq
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;

  state_t            state_q;
  logic [6:0]        ctrl_q;
  logic [DATA_W-1:0] tx_hold_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic [CW-1:0]     bit_cnt_q;
  logic              rx_valid_q, tx_empty_q, overrun_q, underrun_q;

  logic          cpol, cpha, en, rx_ie, err_ie;
  logic [CW-1:0] len_bits;
  logic          edge_seen, lead, trail, sample_ev, shift_ev, cs_fall, start_word;
  logic          wr_en, rd_en, wr_ctrl, wr_status, wr_tx, rd_rx;

  // Pin synchronizers; cs_n resets high so reset release never looks like a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cpol   = ctrl_q[0];
  assign cpha   = ctrl_q[1];
  assign rx_ie  = ctrl_q[4];
  assign err_ie = ctrl_q[5];
  assign en     = ctrl_q[6];

  always_comb begin
    len_bits = CW'(32);
    case (ctrl_q[3:2])
      2'b00:   len_bits = CW'(8);
      2'b01:   len_bits = CW'(16);
      default: len_bits = CW'(32);
    endcase
  end

  assign edge_seen = sclk_s ^ sclk_prev_q;
  assign lead      = edge_seen & (sclk_s != cpol);
  assign trail     = edge_seen & (sclk_s == cpol);
  assign sample_ev = cpha ? trail : lead;
  assign shift_ev  = cpha ? lead : trail;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign start_word = en & (((state_q == S_IDLE) & cs_fall) |
                            ((state_q == S_DONE) & ~cs_s));

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign rd_en     = PSEL & PENABLE & ~PWRITE;
  assign wr_ctrl   = wr_en & (PADDR == 4'h0);
  assign wr_status = wr_en & (PADDR == 4'h4);
  assign wr_tx     = wr_en & (PADDR == 4'h8);
  assign rd_rx     = rd_en & (PADDR == 4'hC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b1;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (wr_ctrl && state_q == S_IDLE) ctrl_q <= PWDATA[6:0];

      // Clears first so that a same-cycle set below takes priority.
      if (rd_rx) rx_valid_q <= 1'b0;
      if (wr_status && PWDATA[2]) overrun_q  <= 1'b0;
      if (wr_status && PWDATA[3]) underrun_q <= 1'b0;

      if (start_word) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
        if (!tx_empty_q) begin
          tx_shift_q <= tx_hold_q;
        end else begin
          tx_shift_q <= '0;
          underrun_q <= 1'b1;
        end
        tx_empty_q <= 1'b1;
      end

      // A software write landing on the load cycle stays pending for the next word.
      if (wr_tx) begin
        tx_hold_q  <= PWDATA[DATA_W-1:0];
        tx_empty_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: if (start_word) state_q <= S_SHIFT;
        S_SHIFT: begin
          if (cs_s) begin
            state_q <= S_IDLE;
          end else begin
            // No shift while bit_cnt is 0: with cpha=1 the first lead edge must
            // present the MSB, and with cpha=0 the trailing edge of the previous
            // word may land after a back-to-back reload.
            if (shift_ev && bit_cnt_q != '0)
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            if (sample_ev) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + CW'(1);
              if (bit_cnt_q + CW'(1) == len_bits) state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A read of RXDATA in this very cycle frees the register for the new word.
          if (rx_valid_q && !rd_rx) begin
            overrun_q <= 1'b1;
          end else begin
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
          end
          state_q <= start_word ? S_SHIFT : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (PADDR)
        4'h0:    PRDATA = {25'd0, ctrl_q};
        4'h4:    PRDATA = {27'd0, (state_q != S_IDLE), underrun_q, overrun_q,
                           tx_empty_q, rx_valid_q};
        4'h8:    PRDATA = 32'(tx_hold_q);
        4'hC:    PRDATA = 32'(rx_data_q);
        default: PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    case (ctrl_q[3:2])
      2'b00:   miso = tx_shift_q[7];
      2'b01:   miso = tx_shift_q[15];
      default: miso = tx_shift_q[31];
    endcase
  end

  assign PREADY  = 1'b1;
  assign miso_oe = ~cs_s;
  assign irq     = (rx_valid_q & rx_ie) | ((overrun_q | underrun_q) & err_ie);

endmodule

// File: tb/tb_spi_target_apb.sv
module tb_spi_target_apb;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, irq;

  int n_cmp = 0;
  int n_bad = 0;

  spi_target_apb #(.SYNC_STAGES(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Master side of one word: nbits of tx (MSB first), returns the miso bits seen.
  task automatic spi_word(input int nbits, input logic cpol, input logic cpha,
                          input logic [31:0] tx, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) mosi = tx[nbits-1-i];
      wait_clk(HALF);
      if (!cpha) rx = {rx[30:0], miso};
      else       mosi = tx[nbits-1-i];
      sclk = ~cpol;
      wait_clk(HALF);
      if (cpha) rx = {rx[30:0], miso};
      sclk = cpol;
    end
  endtask

  logic [31:0] rd, rx1, rx2;

  initial begin
    // Reset state
    wait_clk(3);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_oe", 32'(miso_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    chk("rst_prdata", PRDATA, 32'h0);
    rst = 1'b0;
    wait_clk(2);
    apb_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
    apb_read(4'h4, rd); chk("rst_status", rd, 32'h2);

    // 1: mode 0, 8 bits
    apb_write(4'h0, 32'h50);
    apb_write(4'h8, 32'hA5);
    cs_low();
    wait_clk(4);
    chk("t1_oe", 32'(miso_oe), 32'h1);
    spi_word(8, 1'b0, 1'b0, 32'h3C, rx1);
    cs_high();
    chk("t1_miso", rx1, 32'hA5);
    chk("t1_oe_off", 32'(miso_oe), 32'h0);
    apb_read(4'h4, rd); chk("t1_rxv", 32'(rd[0]), 32'h1);
    chk("t1_irq", 32'(irq), 32'h1);
    apb_read(4'hC, rd); chk("t1_rx", rd, 32'h3C);

    // 2: mode 3, 32 bits
    sclk = 1'b1;
    apb_write(4'h0, 32'h5B);
    apb_write(4'h8, 32'hDEADBEEF);
    cs_low();
    spi_word(32, 1'b1, 1'b1, 32'h12345678, rx1);
    cs_high();
    chk("t2_miso", rx1, 32'hDEADBEEF);
    chk("t2_irq", 32'(irq), 32'h1);
    apb_read(4'hC, rd); chk("t2_rx", rd, 32'h12345678);
    wait_clk(1);
    chk("t2_irq_clr", 32'(irq), 32'h0);
    apb_read(4'h4, rd); chk("t2_rxv_clr", 32'(rd[0]), 32'h0);

    // 3: two 16-bit words back to back, overrun
    sclk = 1'b0;
    apb_write(4'h0, 32'h44);
    apb_write(4'h4, 32'hC);
    apb_write(4'h8, 32'h1111);
    cs_low();
    spi_word(16, 1'b0, 1'b0, 32'hABCD, rx1);
    spi_word(16, 1'b0, 1'b0, 32'h1234, rx2);
    cs_high();
    chk("t3_miso1", rx1, 32'h1111);
    chk("t3_miso2", rx2, 32'h0);
    apb_read(4'h4, rd);
    chk("t3_rxv", 32'(rd[0]), 32'h1);
    chk("t3_ovr", 32'(rd[2]), 32'h1);
    apb_read(4'hC, rd); chk("t3_rx", rd, 32'hABCD);
    apb_write(4'h4, 32'h4);
    apb_read(4'h4, rd); chk("t3_ovr_clr", 32'(rd[2]), 32'h0);

    // 4: underrun, aborted word
    apb_write(4'h0, 32'h40);
    apb_write(4'h4, 32'hC);
    cs_low();
    spi_word(5, 1'b0, 1'b0, 32'h1F, rx1);
    cs_high();
    chk("t4_miso", rx1, 32'h0);
    apb_read(4'h4, rd);
    chk("t4_udr", 32'(rd[3]), 32'h1);
    chk("t4_rxv", 32'(rd[0]), 32'h0);
    chk("t4_busy", 32'(rd[4]), 32'h0);

    // 5: reset mid-word, then a clean transfer
    apb_write(4'h8, 32'h5A);
    cs_low();
    spi_word(3, 1'b0, 1'b0, 32'h5, rx1);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(3);
    chk("t5_miso", 32'(miso), 32'h0);
    chk("t5_oe", 32'(miso_oe), 32'h0);
    chk("t5_irq", 32'(irq), 32'h0);
    chk("t5_pready", 32'(PREADY), 32'h1);
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    apb_read(4'h0, rd); chk("t5_ctrl", rd, 32'h0);
    apb_read(4'h4, rd); chk("t5_status", rd, 32'h2);
    apb_write(4'h0, 32'h50);
    apb_write(4'h8, 32'hC3);
    cs_low();
    spi_word(8, 1'b0, 1'b0, 32'h96, rx1);
    cs_high();
    chk("t5_miso2", rx1, 32'hC3);
    apb_read(4'hC, rd); chk("t5_rx", rd, 32'h96);

    // 6: CTRL write while busy is ignored; en=0 ignores the bus
    apb_write(4'h8, 32'h77);
    cs_low();
    spi_word(4, 1'b0, 1'b0, 32'hE, rx1);
    apb_write(4'h0, 32'h00);
    apb_read(4'h4, rd); chk("t6_busy", 32'(rd[4]), 32'h1);
    apb_read(4'h0, rd); chk("t6_ctrl_keep", rd, 32'h50);
    spi_word(4, 1'b0, 1'b0, 32'h7, rx2);
    cs_high();
    chk("t6_miso", {rx1[27:0], rx2[3:0]}, 32'h77);
    apb_read(4'hC, rd); chk("t6_rx", rd, 32'hE7);
    apb_write(4'h4, 32'hC);
    apb_write(4'h0, 32'h10);
    apb_read(4'h0, rd); chk("t6_ctrl_idle", rd, 32'h10);
    apb_write(4'h8, 32'h11);
    cs_low();
    spi_word(8, 1'b0, 1'b0, 32'hFF, rx1);
    cs_high();
    apb_read(4'h4, rd); chk("t6_noflags", rd, 32'h0);
    chk("t6_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
